// File: rtl/ptp_ts_queue_pkg.sv
// Shared TSU definitions: PTP info word layout, overflow counter width and helpers.
package ptp_ts_queue_pkg;

    localparam int unsigned PTP_INFOR_W = 52;
    localparam int unsigned SEQID_MSB   = 51;
    localparam int unsigned SEQID_LSB   = 36;
    localparam int unsigned MSGID_MSB   = 35;
    localparam int unsigned MSGID_LSB   = 32;
    localparam int unsigned TIME_MSB    = 31;
    localparam int unsigned OVF_CNT_W   = 8;

    localparam logic [OVF_CNT_W-1:0] OVF_MAX = '1;

    typedef struct packed {
        logic [SEQID_MSB-SEQID_LSB:0] seqid;
        logic [MSGID_MSB-MSGID_LSB:0] msgid;
        logic [TIME_MSB:0]            sop_time;
    } ptp_infor_t;

    // Saturating increment for the drop counter.
    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (v == OVF_MAX) ? v : v + OVF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ptp_ts_ram.sv
// Simple dual-port timestamp RAM: synchronous write, registered read with read enable.
module ptp_ts_ram
    import ptp_ts_queue_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [DEPTH_LOG2-1:0]  waddr,
    input  logic [PTP_INFOR_W-1:0] wdata,
    input  logic                   re,
    input  logic [DEPTH_LOG2-1:0]  raddr,
    output logic [PTP_INFOR_W-1:0] rdata
);

    logic [PTP_INFOR_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a same-edge write to raddr returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ptp_ts_queue.sv
// Circular timestamp FIFO between the PTP parser and host registers, with drop counter.
module ptp_ts_queue
    import ptp_ts_queue_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ptp_found,
    input  logic [PTP_INFOR_W-1:0] ptp_infor,
    input  logic                   q_clear,
    input  logic                   rd_req,
    output logic [PTP_INFOR_W-1:0] rd_data,
    output logic                   rd_valid,
    output logic [DEPTH_LOG2:0]    q_count,
    output logic                   q_empty,
    output logic                   q_full,
    output logic [OVF_CNT_W-1:0]   ovf_cnt
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == FULL_COUNT);

    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    always_comb begin
        pop  = rd_req && !q_empty;
        push = ptp_found && (!q_full || pop);
        drop = ptp_found && q_full && !pop;
    end

    ptp_ts_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push && !q_clear),
        .waddr (wp),
        .wdata (ptp_infor),
        .re    (pop && !q_clear),
        .raddr (rp),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            q_count  <= '0;
            ovf_cnt  <= '0;
            rd_valid <= 1'b0;
        end else if (q_clear) begin
            wp       <= '0;
            rp       <= '0;
            q_count  <= '0;
            ovf_cnt  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wp <= wp + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rp <= rp + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + (DEPTH_LOG2+1)'(1);
                2'b01:   q_count <= q_count - (DEPTH_LOG2+1)'(1);
                default: q_count <= q_count;
            endcase
            if (drop) begin
                ovf_cnt <= sat_inc(ovf_cnt);
            end
        end
    end

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Bench for ptp_ts_queue: vector table, directed corner sequences, random vs queue model.
module tb_ptp_ts_queue;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 2**DL2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ptp_found = 1'b0;
    logic [51:0] ptp_infor = '0;
    logic        q_clear = 1'b0;
    logic        rd_req = 1'b0;
    logic [51:0] rd_data;
    logic        rd_valid;
    logic [DL2:0] q_count;
    logic        q_empty;
    logic        q_full;
    logic [7:0]  ovf_cnt;

    ptp_ts_queue #(
        .DEPTH_LOG2(DL2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ptp_found (ptp_found),
        .ptp_infor (ptp_infor),
        .q_clear   (q_clear),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .q_count   (q_count),
        .q_empty   (q_empty),
        .q_full    (q_full),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a plain queue of stored words.
    logic [51:0] mq [$];
    logic        m_valid = 1'b0;
    logic [51:0] m_data  = '0;
    int          m_ovf   = 0;

    typedef struct packed {
        logic        r;
        logic        f;
        logic [51:0] d;
        logic        c;
        logic        q;
        logic        exp_valid;
        logic [51:0] exp_data;
        logic [7:0]  exp_count;
        logic [7:0]  exp_ovf;
    } vec_t;

    function automatic logic [51:0] mk(input logic [15:0] s, input logic [3:0] m,
                                       input logic [31:0] t);
        return {s, m, t};
    endfunction

    function automatic vec_t v(input logic r, input logic f, input logic [51:0] d,
                               input logic c, input logic q, input logic ev,
                               input logic [51:0] ed, input int ec, input int eo);
        vec_t x;
        x.r = r; x.f = f; x.d = d; x.c = c; x.q = q;
        x.exp_valid = ev; x.exp_data = ed; x.exp_count = 8'(ec); x.exp_ovf = 8'(eo);
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic f, input logic [51:0] d,
                                input logic c, input logic q);
        bit popped;
        bit was_full;
        if (r) begin
            mq.delete(); m_valid = 1'b0; m_data = '0; m_ovf = 0;
        end else if (c) begin
            mq.delete(); m_valid = 1'b0; m_ovf = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            popped   = q && (mq.size() > 0);
            m_valid  = popped;
            if (popped) m_data = mq.pop_front();
            if (f) begin
                if (was_full && !popped) m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
                else mq.push_back(d);
            end
        end
    endtask

    task automatic check_model();
        check("rd_valid", 64'(rd_valid), 64'(m_valid));
        check("rd_data", 64'(rd_data), 64'(m_data));
        check("q_count", 64'(q_count), 64'(mq.size()));
        check("q_empty", 64'(q_empty), 64'(mq.size() == 0));
        check("q_full", 64'(q_full), 64'(mq.size() == DEPTH));
        check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
    endtask

    task automatic step(input logic r, input logic f, input logic [51:0] d,
                        input logic c, input logic q);
        rst = r; ptp_found = f; ptp_infor = d; q_clear = c; rd_req = q;
        @(posedge clk);
        model_update(r, f, d, c, q);
        #1;
        n_vec++;
        check_model();
    endtask

    task automatic push(input logic [15:0] s);
        step(1'b0, 1'b1, mk(s, 4'h1, 32'hC0DE_0000 | 32'(s)), 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    vec_t tbl [9];

    initial begin
        tbl[0] = v(1, 0, '0, 0, 0, 0, '0, 0, 0);
        tbl[1] = v(0, 1, mk(16'h0001, 4'h0, 32'h12345678), 0, 0, 0, '0, 1, 0);
        tbl[2] = v(0, 0, '0, 0, 0, 0, '0, 1, 0);
        tbl[3] = v(0, 0, '0, 0, 1, 1, 52'h0001012345678, 0, 0);
        tbl[4] = v(0, 0, '0, 0, 0, 0, 52'h0001012345678, 0, 0);
        tbl[5] = v(0, 0, '0, 0, 1, 0, 52'h0001012345678, 0, 0);
        tbl[6] = v(0, 1, mk(16'h0002, 4'h3, 32'h10), 0, 1, 0, 52'h0001012345678, 1, 0);
        tbl[7] = v(0, 0, '0, 0, 1, 1, 52'h0002300000010, 0, 0);
        tbl[8] = v(0, 0, '0, 0, 0, 0, 52'h0002300000010, 0, 0);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].d, tbl[i].c, tbl[i].q);
            check($sformatf("tbl%0d_valid", i), 64'(rd_valid), 64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_data", i), 64'(rd_data), 64'(tbl[i].exp_data));
            check($sformatf("tbl%0d_count", i), 64'(q_count), 64'(tbl[i].exp_count));
            check($sformatf("tbl%0d_empty", i), 64'(q_empty), 64'(tbl[i].exp_count == 0));
            check($sformatf("tbl%0d_ovf", i), 64'(ovf_cnt), 64'(tbl[i].exp_ovf));
        end

        // Fill past capacity, full-queue push+pop, drain across wrap.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) push(16'(i));
        check("fill_full", 64'(q_full), 64'd1);
        check("fill_count", 64'(q_count), 64'd16);
        check("fill_ovf", 64'(ovf_cnt), 64'd2);
        step(1'b0, 1'b1, mk(16'h00AA, 4'h1, 32'h0), 1'b0, 1'b1);
        check("pp_full_seq", 64'(rd_data[51:36]), 64'd0);
        check("pp_full_count", 64'(q_count), 64'd16);
        check("pp_full_ovf", 64'(ovf_cnt), 64'd2);
        for (int i = 1; i < 16; i++) begin
            pop();
            check($sformatf("drain_seq%0d", i), 64'(rd_data[51:36]), 64'(i));
        end
        pop();
        check("drain_last", 64'(rd_data[51:36]), 64'h00AA);
        pop();
        check("drain_done_valid", 64'(rd_valid), 64'd0);
        check("drain_done_empty", 64'(q_empty), 64'd1);

        // Clear beats same-cycle push and pop.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) push(16'(100 + i));
        for (int i = 0; i < 11; i++) pop();
        check("pre_clr_count", 64'(q_count), 64'd5);
        check("pre_clr_ovf", 64'(ovf_cnt), 64'd3);
        step(1'b0, 1'b1, mk(16'hDEAD, 4'h2, 32'h1), 1'b1, 1'b1);
        check("clr_count", 64'(q_count), 64'd0);
        check("clr_ovf", 64'(ovf_cnt), 64'd0);
        check("clr_valid", 64'(rd_valid), 64'd0);
        push(16'h0BEE);
        pop();
        check("post_clr_seq", 64'(rd_data[51:36]), 64'h0BEE);
        check("post_clr_valid", 64'(rd_valid), 64'd1);
        pop();
        check("post_clr_empty_valid", 64'(rd_valid), 64'd0);

        // Overflow saturation, then reset while reading.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 316; i++) push(16'(i));
        check("sat_ovf", 64'(ovf_cnt), 64'd255);
        pop();
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_count", 64'(q_count), 64'd0);
        check("rst_empty", 64'(q_empty), 64'd1);
        check("rst_full", 64'(q_full), 64'd0);
        check("rst_ovf", 64'(ovf_cnt), 64'd0);

        // Random traffic with phase-varying push/pop bias.
        begin
            int pf = 50;
            int pq = 50;
            for (int i = 0; i < 3000; i++) begin
                if (i % 150 == 0) begin
                    pf = int'($urandom_range(10, 95));
                    pq = int'($urandom_range(10, 95));
                end
                step($urandom_range(0, 499) == 0,
                     $urandom_range(0, 99) < pf,
                     {$urandom, $urandom} & 64'h000F_FFFF_FFFF_FFFF,
                     $urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < pq);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
